// File: rtl/jvm_insn_sequencer.sv
// JVM bytecode fetch/decode sequencer: looks up each opcode's operand count in an external ROM,
// gathers the operand bytes and hands the assembled instruction downstream.
module jvm_insn_sequencer #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned MAX_OPS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           rom_opcode,
  input  logic [4:0]           rom_count,
  input  logic                 flush,
  input  logic [PC_W-1:0]      flush_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_opcode,
  output logic [8*MAX_OPS-1:0] out_operands,
  output logic [4:0]           out_count,
  output logic [PC_W-1:0]      out_pc,
  output logic                 out_err
);

  localparam int unsigned OpW = 8 * MAX_OPS;

  typedef enum logic [1:0] {StIdle, StOper, StEmit} state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [7:0]      opcode_q;
  logic [OpW-1:0]  operands_q;
  logic [4:0]      count_q;
  logic [4:0]      remaining_q;
  logic [PC_W-1:0] out_pc_q;
  logic            err_q;
  logic            valid_q;
  logic            in_fire;

  assign in_ready   = (state_q != StEmit);
  assign in_fire    = in_valid & in_ready;
  // The ROM sees the live byte while waiting for an opcode, the held opcode otherwise.
  assign rom_opcode = (state_q == StIdle) ? in_byte : opcode_q;

  assign out_valid    = valid_q;
  assign out_opcode   = opcode_q;
  assign out_operands = operands_q;
  assign out_count    = count_q;
  assign out_pc       = out_pc_q;
  assign out_err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      opcode_q    <= '0;
      operands_q  <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      out_pc_q    <= '0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else if (flush) begin
      // Redirect wins over any handshake; a byte offered this cycle is dropped.
      state_q <= StIdle;
      valid_q <= 1'b0;
      pc_q    <= flush_pc;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_fire) begin
            opcode_q   <= in_byte;
            out_pc_q   <= pc_q;
            count_q    <= rom_count;
            operands_q <= '0;
            pc_q       <= pc_q + PC_W'(1);
            err_q      <= 1'b0;
            if (rom_count == 5'd0) begin
              state_q <= StEmit;
              valid_q <= 1'b1;
            end else if (rom_count > 5'(MAX_OPS)) begin
              // Switch-class opcode: flag it, leave its operand bytes in the stream.
              err_q   <= 1'b1;
              state_q <= StEmit;
              valid_q <= 1'b1;
            end else begin
              remaining_q <= rom_count;
              state_q     <= StOper;
            end
          end
        end
        StOper: begin
          if (in_fire) begin
            operands_q  <= (operands_q << 8) | OpW'(in_byte);
            remaining_q <= remaining_q - 5'd1;
            pc_q        <= pc_q + PC_W'(1);
            if (remaining_q == 5'd1) begin
              state_q <= StEmit;
              valid_q <= 1'b1;
            end
          end
        end
        StEmit: begin
          if (out_ready) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
